button_debounce: RTL and testbench

//  Input-side counterpart of the board LED drivers: takes one raw, asynchronous,

---
 rtl/button_debounce_pkg.sv | 18 +
 rtl/button_debounce_if.sv | 32 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/button_debounce.sv | 150 +++++++++++++++
 tb/tb_button_debounce.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
// Shared board timing for the button front-end: clock rate and time-to-cycle helpers used to
// size debounce and long-press windows.
package button_debounce_pkg;

   localparam int unsigned CLK_HZ = 50_000_000;
   localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

   // Cycles in a given number of milliseconds at CLK_HZ.
   function automatic int unsigned ms_to_cycles(input int unsigned ms);
      return CYCLES_PER_MS * ms;
   endfunction

   // Counter width able to hold 0 .. cycles-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Signal bundle between a debounced button and its user logic.
// 'release' is a language keyword, so the release pulse is carried as btn_release.
interface button_debounce_if;

   logic btn_in;
   logic btn_level;
   logic press;
   logic btn_release;
   logic long_press;
   logic toggle;

   // Board/user side: drives the raw pin, consumes the clean events.
   modport master (
      output btn_in,
      input  btn_level,
      input  press,
      input  btn_release,
      input  long_press,
      input  toggle
   );

   // Debouncer side.
   modport slave (
      input  btn_in,
      output btn_level,
      output press,
      output btn_release,
      output long_press,
      output toggle
   );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous board inputs.
// Both stages load RESET_VAL under synchronous reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button front-end: synchronizes and debounces a raw pin, then emits registered
// press/release/long-press pulses and a press-toggled bit.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(5),
   parameter int unsigned LONG_CYCLES     = ms_to_cycles(500),
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input logic              clk,
   input logic              rst,
   button_debounce_if.slave bus
);

   localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned HW = cnt_width(LONG_CYCLES);
   localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HCNT_MAX = HW'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StHeld,
      StLong
   } state_e;

   // ---------------------------------------------------------------------------------------
   // Input synchronization: flops reset to the released pin value so that reset never
   // looks like an edge.
   // ---------------------------------------------------------------------------------------
   logic pin_sync;
   logic s;

   sync_2ff #(
      .RESET_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.btn_in),
      .q   (pin_sync)
   );

   assign s = ACTIVE_LOW ? ~pin_sync : pin_sync;

   // ---------------------------------------------------------------------------------------
   // Debounce: any cycle where s agrees with the level restarts the count.
   // ---------------------------------------------------------------------------------------
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          level_q, level_d;
   logic          commit;
   logic          commit_rise;
   logic          commit_fall;

   always_comb begin
      dcnt_d  = '0;
      level_d = level_q;
      commit  = 1'b0;
      if (s != level_q) begin
         if (dcnt_q == DCNT_MAX) begin
            level_d = s;
            commit  = 1'b1;
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end
   end

   assign commit_rise = commit & s;
   assign commit_fall = commit & ~s;

   // ---------------------------------------------------------------------------------------
   // Hold tracking FSM.
   // ---------------------------------------------------------------------------------------
   state_e        state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;
   logic          toggle_q, toggle_d;

   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      case (state_q)
         StIdle: begin
            hcnt_d = '0;
            if (commit_rise) begin
               state_d = StHeld;
               press_d = 1'b1;
            end
         end
         StHeld: begin
            // A release landing on the long-press cycle suppresses the long press.
            if (commit_fall) begin
               state_d   = StIdle;
               release_d = 1'b1;
               hcnt_d    = '0;
            end else if (hcnt_q == HCNT_MAX) begin
               state_d = StLong;
               long_d  = 1'b1;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         StLong: begin
            if (commit_fall) begin
               state_d   = StIdle;
               release_d = 1'b1;
               hcnt_d    = '0;
            end
         end
         default: begin
            state_d = StIdle;
            hcnt_d  = '0;
         end
      endcase
      toggle_d = toggle_q ^ press_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt_q    <= '0;
         level_q   <= 1'b0;
         state_q   <= StIdle;
         hcnt_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         toggle_q  <= 1'b0;
      end else begin
         dcnt_q    <= dcnt_d;
         level_q   <= level_d;
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         toggle_q  <= toggle_d;
      end
   end

   assign bus.btn_level   = level_q;
   assign bus.press       = press_q;
   assign bus.btn_release = release_q;
   assign bus.long_press  = long_q;
   assign bus.toggle      = toggle_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: DEBOUNCE_CYCLES=4, LONG_CYCLES=10, with one
// active-high and one active-low instance sharing clock and reset.
module tb_button_debounce;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic exp_tog;
   logic exp_tog_lo;

   button_debounce_if if_hi ();
   button_debounce_if if_lo ();

   button_debounce #(
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (10),
      .ACTIVE_LOW      (1'b0)
   ) dut_hi (
      .clk (clk),
      .rst (rst),
      .bus (if_hi)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (10),
      .ACTIVE_LOW      (1'b1)
   ) dut_lo (
      .clk (clk),
      .rst (rst),
      .bus (if_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Vector order: {btn_level, press, btn_release, long_press, toggle}

   task automatic test_reset();
      logic [4:0] got;
      rst = 1'b1;
      if_hi.btn_in = 1'b0;
      if_lo.btn_in = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
      n_cmp++;
      if (got !== 5'b00000) begin
         n_err++;
         $display("FAIL reset_hi: got %b want %b", got, 5'b00000);
      end
      got = {if_lo.btn_level, if_lo.press, if_lo.btn_release, if_lo.long_press, if_lo.toggle};
      n_cmp++;
      if (got !== 5'b00000) begin
         n_err++;
         $display("FAIL reset_lo: got %b want %b", got, 5'b00000);
      end
      rst = 1'b0;
      exp_tog = 1'b0;
      exp_tog_lo = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         got = {if_lo.btn_level, if_lo.press, if_lo.btn_release, if_lo.long_press, if_lo.toggle};
         n_cmp++;
         if (got !== 5'b00000) begin
            n_err++;
            $display("FAIL post_reset_lo idle tick %0d: got %b want %b", i, got, 5'b00000);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [4:0] got, exp;
      if_hi.btn_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 6) exp_tog = ~exp_tog;
         exp = {i >= 6, i == 6, 1'b0, 1'b0, exp_tog};
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL clean_press tick %0d: got %b want %b", i, got, exp);
         end
      end
      if_hi.btn_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = {i < 6, 1'b0, i == 6, 1'b0, exp_tog};
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL clean_release tick %0d: got %b want %b", i, got, exp);
         end
      end
   endtask

   task automatic test_bounce();
      logic [4:0] got, exp;
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 4; j++) begin
            if_hi.btn_in = (j < 3);
            tick();
            exp = {1'b0, 1'b0, 1'b0, 1'b0, exp_tog};
            got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press,
                   if_hi.toggle};
            n_cmp++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL bounce rep %0d step %0d: got %b want %b", r, j, got, exp);
            end
         end
      end
      if_hi.btn_in = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         exp = {1'b0, 1'b0, 1'b0, 1'b0, exp_tog};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL bounce_settle tick %0d: got %b want %b", i, got, exp);
         end
      end
   endtask

   task automatic test_long_press();
      logic [4:0] got, exp;
      if_hi.btn_in = 1'b1;
      // Press at tick 6, long press 10 cycles later, then 20 cycles held past the commit.
      for (int i = 1; i <= 26; i++) begin
         tick();
         if (i == 6) exp_tog = ~exp_tog;
         exp = {i >= 6, i == 6, 1'b0, i == 16, exp_tog};
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL long_hold tick %0d: got %b want %b", i, got, exp);
         end
      end
      if_hi.btn_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = {i < 6, 1'b0, i == 6, 1'b0, exp_tog};
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL long_release tick %0d: got %b want %b", i, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] got, exp;
      for (int ph = 0; ph < 4; ph++) begin
         if_hi.btn_in = (ph % 2 == 0);
         for (int i = 1; i <= 8; i++) begin
            tick();
            if (ph % 2 == 0) begin
               if (i == 6) exp_tog = ~exp_tog;
               exp = {i >= 6, i == 6, 1'b0, 1'b0, exp_tog};
            end else begin
               exp = {i < 6, 1'b0, i == 6, 1'b0, exp_tog};
            end
            got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press,
                   if_hi.toggle};
            n_cmp++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL back_to_back phase %0d tick %0d: got %b want %b", ph, i, got, exp);
            end
         end
      end
      n_cmp++;
      if (if_hi.toggle !== 1'b0) begin
         n_err++;
         $display("FAIL back_to_back_toggle: got %b want %b", if_hi.toggle, 1'b0);
      end
   endtask

   // Pin falls 4 cycles after press so the release commits on the long-press cycle.
   task automatic test_release_beats_long();
      logic [4:0] got, exp;
      if_hi.btn_in = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 6) exp_tog = ~exp_tog;
         exp = {i >= 6, i == 6, 1'b0, 1'b0, exp_tog};
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL race_hold tick %0d: got %b want %b", i, got, exp);
         end
      end
      if_hi.btn_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = {i < 6, 1'b0, i == 6, 1'b0, exp_tog};
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL race_release tick %0d: got %b want %b", i, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [4:0] got, exp;
      if_hi.btn_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 6) exp_tog = ~exp_tog;
         exp = {i >= 6, i == 6, 1'b0, 1'b0, exp_tog};
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL rst_hold tick %0d: got %b want %b", i, got, exp);
         end
      end
      rst = 1'b1;
      exp_tog = 1'b0;
      exp_tog_lo = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== 5'b00000) begin
            n_err++;
            $display("FAIL rst_active tick %0d: got %b want %b", i, got, 5'b00000);
         end
      end
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 6) exp_tog = ~exp_tog;
         exp = {i >= 6, i == 6, 1'b0, 1'b0, exp_tog};
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL rst_repress tick %0d: got %b want %b", i, got, exp);
         end
      end
      if_hi.btn_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = {i < 6, 1'b0, i == 6, 1'b0, exp_tog};
         got = {if_hi.btn_level, if_hi.press, if_hi.btn_release, if_hi.long_press, if_hi.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL rst_release tick %0d: got %b want %b", i, got, exp);
         end
      end
   endtask

   task automatic test_active_low();
      logic [4:0] got, exp;
      if_lo.btn_in = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         exp = {1'b0, 1'b0, 1'b0, 1'b0, exp_tog_lo};
         got = {if_lo.btn_level, if_lo.press, if_lo.btn_release, if_lo.long_press, if_lo.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL low_idle tick %0d: got %b want %b", i, got, exp);
         end
      end
      if_lo.btn_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 6) exp_tog_lo = ~exp_tog_lo;
         exp = {i >= 6, i == 6, 1'b0, 1'b0, exp_tog_lo};
         got = {if_lo.btn_level, if_lo.press, if_lo.btn_release, if_lo.long_press, if_lo.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL low_press tick %0d: got %b want %b", i, got, exp);
         end
      end
      if_lo.btn_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = {i < 6, 1'b0, i == 6, 1'b0, exp_tog_lo};
         got = {if_lo.btn_level, if_lo.press, if_lo.btn_release, if_lo.long_press, if_lo.toggle};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL low_release tick %0d: got %b want %b", i, got, exp);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      if_hi.btn_in = 1'b0;
      if_lo.btn_in = 1'b1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_back_to_back();
      test_release_beats_long();
      test_reset_mid_hold();
      test_active_low();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
